// File: rtl/i2si_sample_fifo.sv
// i2si_sample_fifo
//   Sink stage of the I2S-in sample path. A 32-bit word comes from either the
//   BIST generator or the serial deserializer; rf_bist_en picks the source.
//   Each word is buffered in a synchronous FIFO. The register/DMA side reads it
//   back with a one-cycle request/valid handshake. The block reports level,
//   empty/full/almost-full and sticky overflow/underflow flags to the register
//   file.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   rf_bist_en                          1 = BIST source, 0 = deserializer source
//   rf_fifo_clr                         synchronous flush pulse
//   rf_flag_clr                         clears sticky fifo_ovf / fifo_udf
//   i2si_bist_out_data/_xfc             BIST word and its 1-cycle valid strobe
//   i2si_deser_data/_xfc                deserializer word and its valid strobe
//   fifo_rd_req                         read request, 1 cycle per word
//   fifo_rd_data/fifo_rd_valid          registered read data, 1-cycle valid pulse
//   fifo_level                          words stored, 0..DEPTH
//   fifo_empty/full/afull               status derived from the registered level
//   fifo_ovf/fifo_udf                   sticky write-while-full / read-while-empty
module i2si_sample_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rf_bist_en,
  input  logic              rf_fifo_clr,
  input  logic              rf_flag_clr,
  input  logic [DATA_W-1:0] i2si_bist_out_data,
  input  logic              i2si_bist_out_xfc,
  input  logic [DATA_W-1:0] i2si_deser_data,
  input  logic              i2si_deser_xfc,
  input  logic              fifo_rd_req,
  output logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_valid,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_afull,
  output logic              fifo_ovf,
  output logic              fifo_udf
);

  localparam logic [ADDR_W:0] LVL_FULL = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LVL_AF   = AF_THRESH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              src_sel_q;

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full, empty;
  logic              rd_ok, wr_ok;
  logic              ovf_evt, udf_evt;

  // If the source changes, the FIFO flushes in that same cycle. This keeps
  // BIST words and live samples out of the FIFO at the same time.
  assign flush   = rf_fifo_clr | (rf_bist_en != src_sel_q);
  assign wr_en   = rf_bist_en ? i2si_bist_out_xfc  : i2si_deser_xfc;
  assign wr_data = rf_bist_en ? i2si_bist_out_data : i2si_deser_data;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  // When the FIFO is full, a read in the same cycle frees a slot, so the
  // write is also accepted. The write slot is the one being read, and the
  // read sees the old contents because the memory updates at the clock edge.
  assign rd_ok   = fifo_rd_req & ~empty & ~flush;
  assign wr_ok   = wr_en & (~full | rd_ok) & ~flush;
  assign ovf_evt = wr_en & full & ~fifo_rd_req & ~flush;
  assign udf_evt = fifo_rd_req & empty & ~flush;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_ok;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
    // A new event in the same cycle as rf_flag_clr wins, so the flag stays 1.
    ovf_d = (ovf_q & ~rf_flag_clr) | ovf_evt;
    udf_d = (udf_q & ~rf_flag_clr) | udf_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      src_sel_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      src_sel_q  <= rf_bist_en;
    end
  end

  // The storage array has no reset. After a reset the pointers and level are
  // cleared, so none of the old entries can be read.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign fifo_rd_data  = rd_data_q;
  assign fifo_rd_valid = rd_valid_q;
  assign fifo_level    = level_q;
  assign fifo_empty    = empty;
  assign fifo_full     = full;
  assign fifo_afull    = (level_q >= LVL_AF);
  assign fifo_ovf      = ovf_q;
  assign fifo_udf      = udf_q;

endmodule

// File: tb/tb_i2si_sample_fifo.sv
module tb_i2si_sample_fifo;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rf_bist_en, rf_fifo_clr, rf_flag_clr;
  logic [DATA_W-1:0] bist_data, deser_data;
  logic              bist_xfc, deser_xfc, rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, empty, full, afull, ovf, udf;
  logic [ADDR_W:0]   level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  i2si_sample_fifo #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .AF_THRESH(6)) dut (
    .clk(clk), .rst_n(rst_n), .rf_bist_en(rf_bist_en), .rf_fifo_clr(rf_fifo_clr),
    .rf_flag_clr(rf_flag_clr), .i2si_bist_out_data(bist_data), .i2si_bist_out_xfc(bist_xfc),
    .i2si_deser_data(deser_data), .i2si_deser_xfc(deser_xfc), .fifo_rd_req(rd_req),
    .fifo_rd_data(rd_data), .fifo_rd_valid(rd_valid), .fifo_level(level),
    .fifo_empty(empty), .fifo_full(full), .fifo_afull(afull), .fifo_ovf(ovf), .fifo_udf(udf)
  );

  // One clock: inputs stay stable across the edge, outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bist_xfc = 0; deser_xfc = 0; rd_req = 0; rf_fifo_clr = 0; rf_flag_clr = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; rf_bist_en = 0; bist_data = '0; deser_data = '0; idle();
    #12;
    checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || afull !== 1'b0) begin
      failures++; $display("FAIL reset_status level=%0d e=%b f=%b af=%b want 0 1 0 0", level, empty, full, afull); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || ovf !== 1'b0 || udf !== 1'b0) begin
      failures++; $display("FAIL reset_out v=%b d=%h ovf=%b udf=%b want 0 0 0 0", rd_valid, rd_data, ovf, udf); end
    @(negedge clk); rst_n = 1;
    step();
  endtask

  task automatic test_bist_path();
    rf_bist_en = 1; step();   // source switch flushes; FIFO already empty
    for (int i = 1; i <= 5; i++) begin
      bist_xfc = 1; bist_data = i; deser_xfc = 1; deser_data = 32'hDEAD_0000 + i; step();
    end
    idle(); deser_xfc = 0;
    checks++; if (level !== 4'd5) begin failures++; $display("FAIL bist_level got=%0d want=5", level); end
    for (int i = 1; i <= 5; i++) begin
      rd_req = 1; step();
      checks++; if (rd_valid !== 1'b1 || rd_data !== i) begin
        failures++; $display("FAIL bist_read%0d v=%b d=%h want 1 %h", i, rd_valid, rd_data, i); end
    end
    rd_req = 0; step();
    checks++; if (rd_valid !== 1'b0 || level !== 4'd0 || empty !== 1'b1) begin
      failures++; $display("FAIL bist_drain v=%b level=%0d e=%b want 0 0 1", rd_valid, level, empty); end
  endtask

  task automatic test_fill_ovf();
    rf_bist_en = 0; step();
    for (int i = 0; i < 8; i++) begin
      deser_xfc = 1; deser_data = 32'hA0 + i; step();
      if (i == 5) begin
        checks++; if (afull !== 1'b1 || level !== 4'd6) begin
          failures++; $display("FAIL afull_at6 af=%b level=%0d want 1 6", afull, level); end
      end
      if (i == 4) begin
        checks++; if (afull !== 1'b0) begin failures++; $display("FAIL afull_at5 got=%b want=0", afull); end
      end
    end
    checks++; if (full !== 1'b1 || level !== 4'd8 || ovf !== 1'b0) begin
      failures++; $display("FAIL fill8 f=%b level=%0d ovf=%b want 1 8 0", full, level, ovf); end
    deser_data = 32'hEE; step();
    deser_xfc = 0;
    checks++; if (ovf !== 1'b1 || level !== 4'd8) begin
      failures++; $display("FAIL ovf9 ovf=%b level=%0d want 1 8", ovf, level); end
    for (int i = 0; i < 8; i++) begin
      rd_req = 1; step();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA0 + i) begin
        failures++; $display("FAIL fill_read%0d v=%b d=%h want 1 %h", i, rd_valid, rd_data, 32'hA0 + i); end
    end
    rd_req = 0; rf_flag_clr = 1; step(); rf_flag_clr = 0;
    checks++; if (ovf !== 1'b0 || empty !== 1'b1) begin
      failures++; $display("FAIL ovf_clr ovf=%b e=%b want 0 1", ovf, empty); end
  endtask

  task automatic test_full_rw();
    // Start from a non-zero pointer (3) so that the pointers wrap inside the test.
    for (int i = 0; i < 3; i++) begin deser_xfc = 1; deser_data = 32'h11; step(); end
    deser_xfc = 0;
    for (int i = 0; i < 3; i++) begin rd_req = 1; step(); end
    rd_req = 0;
    for (int i = 0; i < 8; i++) begin deser_xfc = 1; deser_data = 32'hB0 + i; step(); end
    deser_data = 32'hC0; rd_req = 1; step();
    deser_xfc = 0;
    checks++; if (level !== 4'd8 || ovf !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 32'hB0) begin
      failures++; $display("FAIL full_rw level=%0d ovf=%b v=%b d=%h want 8 0 1 b0", level, ovf, rd_valid, rd_data); end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (rd_data !== ((i == 8) ? 32'hC0 : 32'hB0 + i)) begin
        failures++; $display("FAIL full_rw_read%0d got=%h want=%h", i, rd_data, (i == 8) ? 32'hC0 : 32'hB0 + i); end
    end
    rd_req = 0; step();
  endtask

  task automatic test_underflow();
    rd_req = 1; step();
    checks++; if (udf !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 32'hC0) begin
      failures++; $display("FAIL udf v=%b udf=%b d=%h want 0 1 c0", rd_valid, udf, rd_data); end
    rf_flag_clr = 1; step();   // new udf event beats the clear
    checks++; if (udf !== 1'b1) begin failures++; $display("FAIL udf_clr_race got=%b want=1", udf); end
    rd_req = 0; step();
    checks++; if (udf !== 1'b0) begin failures++; $display("FAIL udf_clr got=%b want=0", udf); end
    rf_flag_clr = 0; rd_req = 1; deser_xfc = 1; deser_data = 32'hD0; step();
    deser_xfc = 0;
    checks++; if (level !== 4'd1 || udf !== 1'b1 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL empty_rw level=%0d udf=%b v=%b want 1 1 0", level, udf, rd_valid); end
    step();
    rd_req = 0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hD0 || level !== 4'd0) begin
      failures++; $display("FAIL empty_rw_read v=%b d=%h level=%0d want 1 d0 0", rd_valid, rd_data, level); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 2; i++) begin deser_xfc = 1; deser_data = 32'h55; step(); end
    rf_fifo_clr = 1; rd_req = 1; step();
    idle();
    checks++; if (level !== 4'd0 || rd_valid !== 1'b0 || rd_data !== 32'hD0 || udf !== 1'b1) begin
      failures++; $display("FAIL clr level=%0d v=%b d=%h udf=%b want 0 0 d0 1", level, rd_valid, rd_data, udf); end
    for (int i = 0; i < 6; i++) begin deser_xfc = 1; deser_data = 32'h66; step(); end
    deser_xfc = 0;
    checks++; if (level !== 4'd6 || afull !== 1'b1) begin
      failures++; $display("FAIL sw_pre level=%0d af=%b want 6 1", level, afull); end
    rf_bist_en = 1; step();
    checks++; if (level !== 4'd0 || empty !== 1'b1 || afull !== 1'b0 || udf !== 1'b1 || ovf !== 1'b0) begin
      failures++; $display("FAIL src_switch level=%0d e=%b af=%b udf=%b ovf=%b want 0 1 0 1 0", level, empty, afull, udf, ovf); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) begin bist_xfc = 1; bist_data = 32'h70 + i; step(); end
    bist_xfc = 0; rd_req = 1; step();
    checks++; if (level !== 4'd4 || rd_valid !== 1'b1 || rd_data !== 32'h70) begin
      failures++; $display("FAIL pre_rst level=%0d v=%b d=%h want 4 1 70", level, rd_valid, rd_data); end
    #2 rst_n = 0; #1;
    checks++; if (level !== 4'd0 || rd_valid !== 1'b0 || udf !== 1'b0 || empty !== 1'b1 || rd_data !== 32'h0) begin
      failures++; $display("FAIL async_rst level=%0d v=%b udf=%b e=%b d=%h want 0 0 0 1 0", level, rd_valid, udf, empty, rd_data); end
    idle(); rf_bist_en = 0;
    @(negedge clk); rst_n = 1;
    step();
    checks++; if (level !== 4'd0 || rd_valid !== 1'b0) begin
      failures++; $display("FAIL post_rst level=%0d v=%b want 0 0", level, rd_valid); end
  endtask

  initial begin
    test_reset();
    test_bist_path();
    test_fill_ovf();
    test_full_rw();
    test_underflow();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
